// File: rtl/binary_search_ctrl.sv
// Binary-searches an unknown target through an external magnitude comparator.
// Each probe is held SETTLE_CYC cycles, then eg/agb/alb steer the next bound.
module binary_search_ctrl #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_eg,
  input  logic             cmp_agb,
  input  logic             cmp_alb,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] probe_q, probe_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             found_q, found_d, err_q, err_d;
  logic             recalc;
  logic             finish;
  logic [WIDTH:0]   span;

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;
    recalc   = 1'b0;
    finish   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          lo_d    = '0;
          hi_d    = '1;
          found_d = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          recalc  = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          case ({cmp_eg, cmp_agb, cmp_alb})
            3'b100: begin
              found_d = 1'b1;
              finish  = 1'b1;
            end
            3'b010: begin
              if (probe_q == hi_q) finish = 1'b1;
              else begin
                lo_d   = probe_q + 1'b1;
                recalc = 1'b1;
              end
            end
            3'b001: begin
              // probe==lo stops before probe-1 could wrap below zero
              if (probe_q == lo_q) finish = 1'b1;
              else begin
                hi_d   = probe_q - 1'b1;
                recalc = 1'b1;
              end
            end
            default: begin
              err_d  = 1'b1;
              finish = 1'b1;
            end
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      result_d = probe_q;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      state_d  = DONE;
    end

    // Midpoint evaluated one bit wider so hi-lo never wraps.
    span = {1'b0, hi_d} - {1'b0, lo_d};
    if (recalc) begin
      probe_d = lo_d + WIDTH'(span >> 1);
      cnt_d   = CW'(SETTLE_CYC - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Directed bench: instance a uses SETTLE_CYC=1, instance b uses SETTLE_CYC=3.
// Comparator modes: 0 ideal, 1 eg+agb, 2 no flag, 3 always alb, 4 always agb.
module tb_binary_search_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] tgt_a = '0, tgt_b = '0;
  int         mode_a = 0;
  logic       eg_a, agb_a, alb_a, eg_b, agb_b, alb_b;
  logic [3:0] probe_a, probe_b, result_a, result_b;
  logic       busy_a, done_a, found_a, err_a;
  logic       busy_b, done_b, found_b, err_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  binary_search_ctrl #(.WIDTH(4), .SETTLE_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .cmp_eg(eg_a), .cmp_agb(agb_a), .cmp_alb(alb_a),
    .probe(probe_a), .busy(busy_a), .done(done_a),
    .found(found_a), .err(err_a), .result(result_a)
  );

  binary_search_ctrl #(.WIDTH(4), .SETTLE_CYC(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .cmp_eg(eg_b), .cmp_agb(agb_b), .cmp_alb(alb_b),
    .probe(probe_b), .busy(busy_b), .done(done_b),
    .found(found_b), .err(err_b), .result(result_b)
  );

  always_comb begin
    case (mode_a)
      1:       {eg_a, agb_a, alb_a} = 3'b110;
      2:       {eg_a, agb_a, alb_a} = 3'b000;
      3:       {eg_a, agb_a, alb_a} = 3'b001;
      4:       {eg_a, agb_a, alb_a} = 3'b010;
      default: {eg_a, agb_a, alb_a} = {tgt_a == probe_a, tgt_a > probe_a, tgt_a < probe_a};
    endcase
  end
  assign {eg_b, agb_b, alb_b} = {tgt_b == probe_b, tgt_b > probe_b, tgt_b < probe_b};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one search; hist packs probes (one nibble per change), lat counts edges
  // from the start edge to the edge that raises done, bcyc counts busy cycles.
  task automatic run(input int which, input logic [3:0] tgt, input int mode, input bit poke,
                     output int hist, output int lat, output int bcyc);
    logic [3:0] last;
    bit         first;
    hist = 0; lat = 0; bcyc = 0; first = 1'b1; last = '0;
    @(negedge clk);
    if (which == 0) begin tgt_a = tgt; mode_a = mode; start_a = 1'b1; end
    else            begin tgt_b = tgt; start_b = 1'b1; end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    lat = 1;
    while (((which == 0) ? done_a : done_b) == 1'b0 && lat < 40) begin
      if ((which == 0) ? busy_a : busy_b) begin
        bcyc++;
        if (first || last != ((which == 0) ? probe_a : probe_b)) begin
          last = (which == 0) ? probe_a : probe_b;
          hist = (hist << 4) | int'(last);
          first = 1'b0;
        end
      end
      if (poke && lat == 1) start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      lat++;
    end
    chk("done_seen", ((which == 0) ? done_a : done_b), 1);
    chk("busy_at_done", ((which == 0) ? busy_a : busy_b), 0);
    @(posedge clk); #1;
    chk("done_pulse_1cyc", ((which == 0) ? done_a : done_b), 0);
  endtask

  task automatic directed(input string tag, input logic [3:0] tgt, input int mode,
                          input int exp_hist, input int exp_lat, input int exp_found,
                          input int exp_err, input int exp_res);
    int h, l, b;
    run(0, tgt, mode, 1'b0, h, l, b);
    chk({tag, "_probes"}, h, exp_hist);
    chk({tag, "_latency"}, l, exp_lat);
    chk({tag, "_found"}, found_a, exp_found);
    chk({tag, "_err"}, err_a, exp_err);
    chk({tag, "_result"}, result_a, exp_res);
    $display("txn %s: probes=%0h lat=%0d found=%0b err=%0b result=%0d", tag, h, l, found_a, err_a, result_a);
  endtask

  initial begin
    int h, l, b, n;
    bit seen_done;

    #12;
    chk("rst_probe", probe_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_flags", {done_a, found_a, err_a}, 0);
    chk("rst_result", result_a, 0);
    @(negedge clk); rst_n = 1'b1;

    directed("t11",   4'd11, 0, 32'h7B,    3, 1, 0, 11);
    directed("t0",    4'd0,  0, 32'h7310,  5, 1, 0, 0);
    directed("t15",   4'd15, 0, 32'h7BDEF, 6, 1, 0, 15);
    directed("egagb", 4'd5,  1, 32'h7,     2, 0, 1, 7);
    directed("noflg", 4'd5,  2, 32'h7,     2, 0, 1, 7);
    directed("alb",   4'd9,  3, 32'h7310,  5, 0, 0, 0);
    directed("agb",   4'd2,  4, 32'h7BDEF, 6, 0, 0, 15);
    chk("err_cleared_by_start", err_a, 0);

    // start pulsed during the search must not disturb or re-launch it
    run(0, 4'd11, 0, 1'b1, h, l, b);
    chk("busy_start_probes", h, 32'h7B);
    chk("busy_start_result", result_a, 11);
    @(posedge clk); #1;
    chk("busy_start_no_relaunch", busy_a, 0);
    $display("txn start_during_busy: probes=%0h result=%0d", h, result_a);

    // start held high: relaunch on the edge after DONE->IDLE
    @(negedge clk); tgt_a = 4'd11; mode_a = 0; start_a = 1'b1;
    n = 0;
    while (!done_a && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_first_done", done_a, 1);
    @(posedge clk); #1;
    chk("b2b_idle_gap", busy_a, 0);
    @(posedge clk); #1;
    chk("b2b_relaunch_busy", busy_a, 1);
    chk("b2b_relaunch_probe", probe_a, 7);
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_second_done", done_a, 1);
    chk("b2b_second_result", result_a, 11);
    $display("txn back_to_back: second result=%0d", result_a);
    @(posedge clk); #1;

    // async reset during the 2nd probe
    @(negedge clk); tgt_a = 4'd0; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_probe2", probe_a, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_probe", probe_a, 0);
    chk("rst_mid_outs", {done_a, found_a, err_a, result_a}, 0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) seen_done = 1'b1;
    end
    chk("rst_mid_no_activity", seen_done, 0);
    $display("txn reset_mid_search: outputs cleared");

    // SETTLE_CYC=3 sweep over every target
    for (int t = 0; t < 16; t++) begin
      run(1, 4'(t), 0, 1'b0, h, l, b);
      n = 0;
      for (int k = 0; k < 8; k++) if (((h >> (4 * k)) & 15) != 0 || k == 0) n = (h >> (4 * k)) != 0 ? k + 1 : n;
      chk("sweep_found", found_b, 1);
      chk("sweep_result", result_b, t);
      chk("sweep_err", err_b, 0);
      chk("sweep_iter_le5", (b <= 15), 1);
      chk("sweep_settle3", b % 3, 0);
      chk("sweep_first_probe", (h >> (4 * ((b / 3) - 1))) & 15, 7);
      $display("txn sweep t=%0d: probes=%0h busy_cycles=%0d result=%0d", t, h, b, result_b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binary_search_ctrl.md
Name: binary_search_ctrl

Overview:
- Sequential consumer of magnitude-compare flags (eg/agb/alb), i.e. the driving end of the comparator interface.
- Drives a probe word into an external comparator whose other operand is an unknown target, and binary-searches for the target value.
- Reports the matched value, or not-found/error.
- Used to recover a set-point or count value that is exposed only through a comparator, e.g. the four-bit comparator path.

Parameters:
- WIDTH, 4: probe/result width in bits.
- SETTLE_CYC, 1: cycles each probe is held before the flags are sampled (>=1; combinational comparator path).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin search; sampled only in IDLE
- cmp_eg  in  1  target == probe
- cmp_agb  in  1  target > probe
- cmp_alb  in  1  target < probe
- probe  out  WIDTH  value driven to comparator operand b
- busy  out  1  search in progress
- done  out  1  one-cycle pulse, search finished
- found  out  1  result valid match; held until next start
- err  out  1  illegal flag combination seen; held until next start
- result  out  WIDTH  matched value (or probe at failure); held until next start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, probe=0, busy=0, done=0, found=0, err=0, result=0, lo=0, hi=0, settle counter=0. Reset mid-search aborts immediately; no done pulse. Search restarts only on a new start after release.
- Registers: lo and hi (WIDTH bits, inclusive bounds); settle counter (enough bits for SETTLE_CYC-1).
- Probe arithmetic: probe = lo + ((hi - lo) >> 1), computed WIDTH+1 bits wide. Result is floor of midpoint; no overflow.
- State IDLE: busy=0. start=1 at edge E0 → lo=0, hi=2^WIDTH-1, probe=2^(WIDTH-1)-1, counter=SETTLE_CYC-1, found=0, err=0, busy=1, state=SEARCH.
- State SEARCH, counter≠0: decrement; probe stable.
- State SEARCH, counter==0: sample flags on this edge. Exactly one flag high is legal; otherwise error.
  - eg: result=probe, found=1 → DONE.
  - agb with probe==hi: result=probe, found=0 → DONE (not found).
  - agb otherwise: lo=probe+1, recompute probe, counter=SETTLE_CYC-1.
  - alb with probe==lo: result=probe, found=0 → DONE (not found).
  - alb otherwise: hi=probe-1, recompute probe, counter=SETTLE_CYC-1.
  - zero or >1 flags high: err=1, found=0, result=probe → DONE.
- State DONE: lasts one cycle. done=1, busy=0. Unconditionally → IDLE; done deasserts next cycle.
- start while busy or in DONE: ignored. start held high continuously re-triggers once per IDLE visit.
- Timing:
  - The probe for iteration k is valid from edge E0+(k-1)*SETTLE_CYC.
  - Its flags are sampled at edge E0+k*SETTLE_CYC.
  - done is high in the cycle after the final sampling edge.
  - Max iterations: WIDTH+1; worst-case latency start→done = (WIDTH+1)*SETTLE_CYC+1 edges.
- probe holds its last value in IDLE/DONE.

Test Plan:
- WIDTH=4, SETTLE_CYC=1, ideal comparator, target=11 → probes 7, 11; done 3 edges after start; found=1, result=11, err=0.
- Target=0 → probes 7, 3, 1, 0; found=1, result=0, 4 iterations.
- Target=15 → probes 7, 11, 13, 14, 15; found=1, result=15, 5 iterations (worst case).
- Sweep all targets 0..15 with SETTLE_CYC=3 → always found, result==target, iterations ≤5, probe stable 3 cycles per step.
- Fault injection:
  - Force cmp_eg=cmp_agb=1 at the first sample → err=1, found=0, result=7, done after 1 iteration.
  - Force all flags 0 → same err response.
  - Comparator always alb → probes 7, 3, 1, 0, then found=0, err=0, result=0.
  - Comparator always agb → probes end at 15, found=0, result=15.
- Protocol and reset:
  - Pulse rst_n low during the 2nd probe → all outputs 0 immediately, no done pulse.
  - start during busy ignored.
  - Back-to-back start held high → second search begins the edge after DONE→IDLE.
